mic_sample_reader: RTL and testbench
====================================

# mic_sample_reader

Capture-side counterpart of the tone/audio output path. The block periodically reads 12-bit samples from the on-board microphone ADC (ADCS7476-style serial interface: 16-bit frame with 4 leading zeros, then 12 data bits MSB first). It acts as the serial master, generating chip-select and serial clock from the 100 MHz system clock. Each sample is presented to downstream logic (level meter, loopback to the audio output) through a one-entry valid/ready register, with sticky overrun and frame-error flags.

## Interface
Parameters:
- CLK_DIV, default 4: `clk` cycles per `mic_sclk` half-period (12.5 MHz SCLK at default); legal range ≥ 2.
- SAMPLE_DIV, default 2268: `clk` cycles per sample slot (≈44.09 kHz); must be ≥ 33*CLK_DIV+2, enforced by an elaboration-time check.

Ports:
- clk  in  1  100 MHz system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = sample continuously.
- mic_miso  in  1  ADC serial data.
- mic_cs_n  out  1  ADC chip select, active low.
- mic_sclk  out  1  ADC serial clock, idles high.
- sample  out  12  raw offset-binary sample.
- sample_signed  out  12  two's complement sample (`sample` with MSB inverted).
- sample_valid  out  1  sample register holds unconsumed data.
- sample_ready  in  1  consumer accepts when `sample_valid` && `sample_ready`.
- overrun  out  1  sticky: an unconsumed sample was overwritten.
- frame_err  out  1  sticky: a leading-zero bit was read as 1.
- clear_flags  in  1  synchronous clear of `overrun` and `frame_err`.

## Operation
- All outputs are registered.
- Reset values:
  - `mic_cs_n`=1, `mic_sclk`=1.
  - `sample`=0, `sample_signed`=0x800.
  - `sample_valid`=0, `overrun`=0, `frame_err`=0.
  - FSM=IDLE; all counters=0.
- Slot counter: counts 0..SAMPLE_DIV-1 and wraps while `enable`=1. It is held at 0 while `enable`=0.
- FSM states:
  - IDLE: leave on slot counter==0 && `enable` && no frame in progress; go to SETUP.
  - SETUP: `mic_cs_n`=0 for CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 16 bit periods. Each period drives `mic_sclk` low for CLK_DIV cycles, then high for CLK_DIV cycles. After 16 periods, go to HOLD.
  - HOLD: `mic_cs_n`=0, `mic_sclk`=1 for CLK_DIV cycles, then return to IDLE with `mic_cs_n`=1.
- Capture:
  - `mic_miso` is shifted into a 16-bit register on the `clk` cycle in which `mic_sclk` transitions 0→1.
  - Bits 15..12 are the leading zeros; bits 11..0 are the sample.
- Frame completion, in the cycle `mic_cs_n` returns to 1:
  - `sample` is loaded; `sample_valid` is set to 1.
  - If any leading bit = 1, `frame_err` is set; the sample is still delivered.
- Handshake:
  - `sample_valid` stays high and `sample` stays stable until a cycle with `sample_ready`=1.
  - `sample_valid` clears the cycle after acceptance, unless a new sample lands in that same cycle.
- Boundary conditions:
  - New sample while valid && !ready: overwrite `sample`, keep valid=1, set `overrun`.
  - New sample while valid && ready: no overrun; the old sample is consumed and the new one is loaded.
  - `clear_flags` and a flag-set event in the same cycle: set wins.
  - `enable` deasserted mid-frame: the current frame completes and delivers its sample; no further frames start.
  - `rst_n` low mid-frame: `mic_cs_n`/`mic_sclk` go to 1 immediately (asynchronously); the partial frame is discarded.

## Timing
- Let t0 be the first cycle with `mic_cs_n`=0.
  - `mic_sclk` falls at t0+(2k+1)*CLK_DIV.
  - Capture edge for bit k (k=0..15, k=0 is the first leading zero) is at t0+(2k+2)*CLK_DIV.
  - Last capture at t0+32*CLK_DIV.
  - `mic_cs_n` rises and `sample_valid` rises at t0+33*CLK_DIV (132 cycles at default).
- First frame: t0 is one cycle after the first rising `clk` edge that samples `enable`=1.
- Frame start period: exactly SAMPLE_DIV cycles while `enable` stays high.
- Minimum `mic_cs_n` high time between frames: SAMPLE_DIV-33*CLK_DIV cycles (≥ 2).
- Consumer latency: a sample may be accepted the same cycle `sample_valid` rises.

## Structure
- Shared package `mic_pkg` holds:
  - FSM state enum (IDLE, SETUP, SHIFT, HOLD);
  - FRAME_BITS=16, LEAD_ZEROS=4, DATA_BITS=12;
  - default CLK_DIV/SAMPLE_DIV.
- One sub-module: `mic_slot_timer`, the sample-slot counter with enable-hold; it emits a one-cycle `slot_start` pulse.
- The FSM, SCLK half-period counter, bit counter, shift register and output register remain in `mic_sample_reader`.

## Test plan
- ADC model returns 0x0A5C, `sample_ready` tied 1 → `sample`=0xA5C, `sample_signed`=0x25C, `sample_valid` pulses 1 cycle at t0+132; `mic_sclk` shows 16 falling edges within `mic_cs_n` low.
- `enable` held 1 for 3*SAMPLE_DIV cycles → exactly 3 `mic_cs_n` falling edges, 2268 cycles apart.
- `sample_ready`=0, frames 0x0123 then 0x0456 → `sample`=0x456, `overrun`=1; one `clear_flags` pulse → `overrun`=0; `sample_valid` remains 1.
- ADC returns 0x8FFF → `sample`=0xFFF, `frame_err`=1; `clear_flags` asserted in the completion cycle → `frame_err`=1.
- `enable` dropped at t0+40 → frame completes, `sample_valid` rises at t0+132, no further `mic_cs_n` falls.
- `rst_n` pulsed low at t0+60 → `mic_cs_n`=1, `mic_sclk`=1 immediately; `sample_valid`=0; restart timing as from enable.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared types and constants for the microphone ADC capture path.
package mic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } mic_state_e;

  localparam int FRAME_BITS     = 16;
  localparam int LEAD_ZEROS     = 4;
  localparam int DATA_BITS      = 12;

  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_SAMPLE_DIV = 2268;

endpackage

// File: rtl/mic_slot_timer.sv
// Sample-slot counter: runs 0..SAMPLE_DIV-1 while enabled, parked at 0 otherwise.
// slot_start_o marks the first cycle of each slot.
module mic_slot_timer #(
  parameter int SAMPLE_DIV = 2268
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  output logic slot_start_o
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: hold at zero when disabled, otherwise wrap at the slot length.
  always_comb begin
    cnt_d = '0;
    if (enable_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Slot counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign slot_start_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/mic_sample_reader.sv
// Serial master for an ADCS7476-style microphone ADC. Reads one 16-bit frame per
// sample slot and presents the 12-bit result through a one-entry valid/ready
// register with sticky overrun and frame-error flags.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | cs_n high, waiting for the next slot start
//   ST_SETUP | cs_n low, sclk high, one half-period before the first fall
//   ST_SHIFT | 16 sclk periods; ends after the 16th low half (last capture)
//   ST_HOLD  | final sclk-high half with cs_n low, then frame completes
module mic_sample_reader
  import mic_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 mic_miso,
  output logic                 mic_cs_n,
  output logic                 mic_sclk,
  output logic [DATA_BITS-1:0] sample,
  output logic [DATA_BITS-1:0] sample_signed,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  output logic                 frame_err,
  input  logic                 clear_flags
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

  if (CLK_DIV < 2) begin : g_chk_clk_div
    $error("mic_sample_reader: CLK_DIV must be at least 2");
  end
  if (SAMPLE_DIV < 33 * CLK_DIV + 2) begin : g_chk_sample_div
    $error("mic_sample_reader: SAMPLE_DIV must be at least 33*CLK_DIV+2");
  end

  logic slot_start;

  mic_slot_timer #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_slot_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable),
    .slot_start_o (slot_start)
  );

  mic_state_e            state_q, state_d;
  logic [HW-1:0]         half_q, half_d;
  logic [3:0]            bit_q, bit_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic [FRAME_BITS-1:0] shift_q;
  logic                  capture;
  logic                  frame_done;

  logic [DATA_BITS-1:0]  sample_q, sample_d;
  logic [DATA_BITS-1:0]  signed_q, signed_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  ferr_q, ferr_d;

  // Frame sequencer: next state, half-period/bit counters and pin levels.
  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    bit_d      = bit_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    capture    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        if (slot_start) begin
          state_d = ST_SETUP;
          half_d  = HALF_LAST;
          cs_n_d  = 1'b0;
        end
      end
      ST_SETUP: begin
        if (half_q == '0) begin
          state_d = ST_SHIFT;
          half_d  = HALF_LAST;
          sclk_d  = 1'b0;
          bit_d   = '0;
        end else begin
          half_d = half_q - HW'(1);
        end
      end
      ST_SHIFT: begin
        if (half_q == '0) begin
          half_d = HALF_LAST;
          if (!sclk_q) begin
            // Rising sclk: this is the capture edge for bit_q.
            sclk_d  = 1'b1;
            capture = 1'b1;
            if (bit_q == LAST_BIT) state_d = ST_HOLD;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 4'd1;
          end
        end else begin
          half_d = half_q - HW'(1);
        end
      end
      ST_HOLD: begin
        if (half_q == '0) begin
          state_d    = ST_IDLE;
          cs_n_d     = 1'b1;
          frame_done = 1'b1;
          bit_d      = '0;
        end else begin
          half_d = half_q - HW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        half_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Sequencer registers; pins return high asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      half_q  <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
    end
  end

  // Serial-in shift register, MSB of the frame arrives first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       shift_q <= '0;
    else if (capture) shift_q <= {shift_q[FRAME_BITS-2:0], mic_miso};
  end

  // Output register and flags; a completing frame overrides acceptance and clear.
  always_comb begin
    sample_d  = sample_q;
    signed_d  = signed_q;
    valid_d   = valid_q;
    overrun_d = overrun_q & ~clear_flags;
    ferr_d    = ferr_q & ~clear_flags;
    if (valid_q && sample_ready) valid_d = 1'b0;
    if (frame_done) begin
      sample_d = shift_q[DATA_BITS-1:0];
      signed_d = {~shift_q[DATA_BITS-1], shift_q[DATA_BITS-2:0]};
      valid_d  = 1'b1;
      if (valid_q && !sample_ready) overrun_d = 1'b1;
      if (|shift_q[FRAME_BITS-1 -: LEAD_ZEROS]) ferr_d = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q  <= '0;
      signed_q  <= {1'b1, {(DATA_BITS-1){1'b0}}};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      signed_q  <= signed_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  assign mic_cs_n      = cs_n_q;
  assign mic_sclk      = sclk_q;
  assign sample        = sample_q;
  assign sample_signed = signed_q;
  assign sample_valid  = valid_q;
  assign overrun       = overrun_q;
  assign frame_err     = ferr_q;

endmodule

// File: tb/tb_mic_sample_reader.sv
// Bench for mic_sample_reader: behavioural ADC on the serial pins, a pin
// monitor timestamping frames, and one task per scenario.
module tb_mic_sample_reader;

  localparam int CLK_DIV    = 4;
  localparam int SAMPLE_DIV = 2268;
  localparam int FRAME_LEN  = 33 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        mic_miso = 1'b0;
  logic        sample_ready = 1'b1;
  logic        clear_flags = 1'b0;
  logic        mic_cs_n, mic_sclk, sample_valid, overrun, frame_err;
  logic [11:0] sample, sample_signed;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mic_sample_reader #(
    .CLK_DIV    (CLK_DIV),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .mic_miso      (mic_miso),
    .mic_cs_n      (mic_cs_n),
    .mic_sclk      (mic_sclk),
    .sample        (sample),
    .sample_signed (sample_signed),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overrun       (overrun),
    .frame_err     (frame_err),
    .clear_flags   (clear_flags)
  );

  // ADC model: each frame takes the next queued word; every sclk fall shifts out one bit, MSB first.
  logic [15:0] adc_q[$];
  logic [15:0] adc_word = 16'h0000;
  int          adc_idx  = 15;

  always @(negedge mic_cs_n) begin
    adc_idx = 15;
    if (adc_q.size() != 0) adc_word = adc_q.pop_front();
    else                   adc_word = 16'h0000;
  end

  always @(negedge mic_sclk) begin
    if (mic_cs_n === 1'b0 && adc_idx >= 0) begin
      mic_miso = adc_word[adc_idx];
      adc_idx--;
    end
  end

  // Pin monitor: timestamps cs_n edges, counts sclk falls per frame, logs delivered samples.
  int          cs_fall_n = 0, cs_rise_n = 0;
  int          t0_last = 0, rise_last = 0;
  int          sclk_falls = 0, sclk_falls_last = 0;
  int          fall_times[$];
  logic [11:0] got_q[$];
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;

  always @(negedge clk) begin
    if (prev_cs === 1'b1 && mic_cs_n === 1'b0) begin
      cs_fall_n++;
      t0_last = cyc;
      fall_times.push_back(cyc);
      sclk_falls = 0;
    end
    if (mic_cs_n === 1'b0 && prev_sclk === 1'b1 && mic_sclk === 1'b0) sclk_falls++;
    if (prev_cs === 1'b0 && mic_cs_n === 1'b1 && rst_n === 1'b1) begin
      cs_rise_n++;
      rise_last = cyc;
      sclk_falls_last = sclk_falls;
      got_q.push_back(sample);
    end
    prev_cs   = mic_cs_n;
    prev_sclk = mic_sclk;
  end

  function automatic logic [11:0] ref_signed(input logic [15:0] w);
    return w[11:0] ^ 12'h800;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fall(input int target, input int budget, output bit to);
    int n = 0;
    while (cs_fall_n < target && n < budget) begin tick(); n++; end
    to = (cs_fall_n < target);
  endtask

  task automatic wait_rise(input int target, input int budget, output bit to);
    int n = 0;
    while (cs_rise_n < target && n < budget) begin tick(); n++; end
    to = (cs_rise_n < target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({mic_cs_n, mic_sclk} !== 2'b11) begin
      n_fail++; $display("FAIL reset_pins got cs_n/sclk=%b expected 11", {mic_cs_n, mic_sclk});
    end
    n_checks++;
    if (sample !== 12'h000) begin
      n_fail++; $display("FAIL reset_sample got %h expected 000", sample);
    end
    n_checks++;
    if (sample_signed !== 12'h800) begin
      n_fail++; $display("FAIL reset_signed got %h expected 800", sample_signed);
    end
    n_checks++;
    if ({sample_valid, overrun, frame_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got v/o/e=%b expected 000", {sample_valid, overrun, frame_err});
    end
    rst_n = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (mic_cs_n !== 1'b1 || cs_fall_n != 0) begin
      n_fail++; $display("FAIL idle_disabled got cs_n=%b falls=%0d expected 1/0", mic_cs_n, cs_fall_n);
    end
  endtask

  task automatic test_single_frame();
    bit to;
    int start, bf, br;
    adc_q.push_back(16'h0A5C);
    sample_ready = 1'b1;
    tick();
    start = cyc; bf = cs_fall_n; br = cs_rise_n;
    enable = 1'b1;
    wait_fall(bf + 1, 10, to);
    n_checks++;
    if (to || t0_last != start + 1) begin
      n_fail++; $display("FAIL first_t0 got t0=%0d timeout=%0b expected %0d", t0_last, to, start + 1);
    end
    wait_rise(br + 1, FRAME_LEN + 10, to);
    n_checks++;
    if (to || rise_last - t0_last != FRAME_LEN) begin
      n_fail++; $display("FAIL frame_len got %0d timeout=%0b expected %0d", rise_last - t0_last, to, FRAME_LEN);
    end
    n_checks++;
    if (sclk_falls_last != 16) begin
      n_fail++; $display("FAIL sclk_falls got %0d expected 16", sclk_falls_last);
    end
    n_checks++;
    if (sample !== 12'hA5C || sample_signed !== 12'h25C) begin
      n_fail++; $display("FAIL single_sample got %h/%h expected a5c/25c", sample, sample_signed);
    end
    n_checks++;
    if (sample_valid !== 1'b1) begin
      n_fail++; $display("FAIL valid_rise got %b expected 1", sample_valid);
    end
    enable = 1'b0;
    tick();
    n_checks++;
    if (sample_valid !== 1'b0) begin
      n_fail++; $display("FAIL valid_pulse got %b expected 0", sample_valid);
    end
    repeat (10) tick();
  endtask

  task automatic test_period();
    logic [15:0] w[3];
    int start, bf, br, nf;
    for (int i = 0; i < 3; i++) begin
      w[i] = 16'($urandom_range(0, 16'h0FFF));
      adc_q.push_back(w[i]);
    end
    tick();
    start = cyc; bf = fall_times.size(); br = got_q.size(); nf = cs_fall_n;
    enable = 1'b1;
    repeat (3 * SAMPLE_DIV) tick();
    enable = 1'b0;
    repeat (FRAME_LEN + 20) tick();
    n_checks++;
    if (cs_fall_n - nf != 3) begin
      n_fail++; $display("FAIL period_count got %0d frames expected 3", cs_fall_n - nf);
    end
    if (fall_times.size() >= bf + 3 && got_q.size() >= br + 3) begin
      n_checks++;
      if (fall_times[bf] != start + 1) begin
        n_fail++; $display("FAIL period_t0 got %0d expected %0d", fall_times[bf], start + 1);
      end
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (fall_times[bf+i] - fall_times[bf+i-1] != SAMPLE_DIV) begin
          n_fail++; $display("FAIL period_gap%0d got %0d expected %0d", i, fall_times[bf+i] - fall_times[bf+i-1], SAMPLE_DIV);
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got_q[br+i] !== w[i][11:0]) begin
          n_fail++; $display("FAIL period_sample%0d got %h expected %h", i, got_q[br+i], w[i][11:0]);
        end
      end
    end
    n_checks++;
    if (overrun !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL period_flags got o/e=%b%b expected 00", overrun, frame_err);
    end
  endtask

  task automatic test_overrun();
    bit to;
    int br;
    sample_ready = 1'b0;
    adc_q.push_back(16'h0123);
    adc_q.push_back(16'h0456);
    tick();
    br = cs_rise_n;
    enable = 1'b1;
    wait_rise(br + 1, FRAME_LEN + 10, to);
    n_checks++;
    if (to || sample !== 12'h123 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_first got %h o=%b timeout=%0b expected 123 o=0", sample, overrun, to);
    end
    wait_rise(br + 2, SAMPLE_DIV + 10, to);
    enable = 1'b0;
    n_checks++;
    if (to || sample !== 12'h456 || overrun !== 1'b1 || sample_valid !== 1'b1) begin
      n_fail++; $display("FAIL overrun_set got %h o=%b v=%b timeout=%0b expected 456 o=1 v=1", sample, overrun, sample_valid, to);
    end
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    n_checks++;
    if (overrun !== 1'b0 || sample_valid !== 1'b1 || sample !== 12'h456) begin
      n_fail++; $display("FAIL overrun_clear got o=%b v=%b %h expected o=0 v=1 456", overrun, sample_valid, sample);
    end
    sample_ready = 1'b1;
    tick();
    n_checks++;
    if (sample_valid !== 1'b0) begin
      n_fail++; $display("FAIL overrun_accept got v=%b expected 0", sample_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int bf, br;
    logic [15:0] wa, wb;
    wa = 16'($urandom_range(0, 16'h0FFF));
    wb = 16'($urandom_range(0, 16'h0FFF));
    adc_q.push_back(wa);
    adc_q.push_back(wb);
    sample_ready = 1'b0;
    tick();
    bf = cs_fall_n; br = cs_rise_n;
    enable = 1'b1;
    wait_rise(br + 1, FRAME_LEN + 10, to);
    n_checks++;
    if (to || sample !== wa[11:0]) begin
      n_fail++; $display("FAIL b2b_first got %h timeout=%0b expected %h", sample, to, wa[11:0]);
    end
    wait_fall(bf + 2, SAMPLE_DIV + 10, to);
    enable = 1'b0;
    repeat (FRAME_LEN - 1) tick();
    sample_ready = 1'b1;
    tick();
    n_checks++;
    if (to || mic_cs_n !== 1'b1 || sample !== wb[11:0] || sample_valid !== 1'b1 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL b2b_collide got cs_n=%b %h v=%b o=%b timeout=%0b expected 1 %h 1 0", mic_cs_n, sample, sample_valid, overrun, to, wb[11:0]);
    end
    tick();
    n_checks++;
    if (sample_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept got v=%b expected 0", sample_valid);
    end
  endtask

  task automatic test_frame_err();
    bit to;
    int bf;
    adc_q.push_back(16'h8FFF);
    sample_ready = 1'b1;
    tick();
    bf = cs_fall_n;
    enable = 1'b1;
    wait_fall(bf + 1, 10, to);
    enable = 1'b0;
    repeat (FRAME_LEN - 1) tick();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    n_checks++;
    if (to || mic_cs_n !== 1'b1 || sample !== 12'hFFF || sample_signed !== ref_signed(16'h8FFF)) begin
      n_fail++; $display("FAIL ferr_sample got cs_n=%b %h/%h timeout=%0b expected 1 fff/7ff", mic_cs_n, sample, sample_signed, to);
    end
    n_checks++;
    if (frame_err !== 1'b1) begin
      n_fail++; $display("FAIL ferr_set_wins got %b expected 1", frame_err);
    end
    tick();
    n_checks++;
    if (frame_err !== 1'b1) begin
      n_fail++; $display("FAIL ferr_sticky got %b expected 1", frame_err);
    end
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL ferr_clear got %b expected 0", frame_err);
    end
  endtask

  task automatic test_enable_drop();
    bit to;
    int bf, br, nf;
    logic [15:0] w;
    w = 16'($urandom_range(0, 16'h0FFF));
    adc_q.push_back(w);
    tick();
    bf = cs_fall_n; br = cs_rise_n;
    enable = 1'b1;
    wait_fall(bf + 1, 10, to);
    repeat (40) tick();
    enable = 1'b0;
    wait_rise(br + 1, FRAME_LEN + 10, to);
    n_checks++;
    if (to || rise_last - t0_last != FRAME_LEN || sample !== w[11:0] || sample_valid !== 1'b1) begin
      n_fail++; $display("FAIL drop_complete got len=%0d %h v=%b timeout=%0b expected %0d %h 1", rise_last - t0_last, sample, sample_valid, to, FRAME_LEN, w[11:0]);
    end
    nf = cs_fall_n;
    repeat (SAMPLE_DIV + 200) tick();
    n_checks++;
    if (cs_fall_n != nf) begin
      n_fail++; $display("FAIL drop_no_restart got %0d new frames expected 0", cs_fall_n - nf);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    int bf, br, rel;
    logic [15:0] w1, w2;
    w1 = 16'($urandom_range(0, 16'h0FFF));
    w2 = 16'($urandom_range(0, 16'h0FFF));
    adc_q.push_back(w1);
    adc_q.push_back(w2);
    tick();
    bf = cs_fall_n;
    enable = 1'b1;
    wait_fall(bf + 1, 10, to);
    repeat (60) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (to || {mic_cs_n, mic_sclk} !== 2'b11) begin
      n_fail++; $display("FAIL rst_async_pins got %b timeout=%0b expected 11", {mic_cs_n, mic_sclk}, to);
    end
    n_checks++;
    if (sample_valid !== 1'b0 || sample !== 12'h000) begin
      n_fail++; $display("FAIL rst_async_out got v=%b %h expected 0 000", sample_valid, sample);
    end
    tick();
    tick();
    rst_n = 1'b1;
    rel = cyc; bf = cs_fall_n; br = cs_rise_n;
    wait_fall(bf + 1, 10, to);
    n_checks++;
    if (to || t0_last != rel + 1) begin
      n_fail++; $display("FAIL rst_restart got t0=%0d timeout=%0b expected %0d", t0_last, to, rel + 1);
    end
    enable = 1'b0;
    wait_rise(br + 1, FRAME_LEN + 10, to);
    n_checks++;
    if (to || sample !== w2[11:0] || sample_signed !== ref_signed(w2) || rise_last - t0_last != FRAME_LEN) begin
      n_fail++; $display("FAIL rst_new_frame got %h/%h len=%0d timeout=%0b expected %h/%h %0d", sample, sample_signed, rise_last - t0_last, to, w2[11:0], ref_signed(w2), FRAME_LEN);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_period();
    test_overrun();
    test_back_to_back();
    test_frame_err();
    test_enable_drop();
    test_reset_mid_frame();
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
